// File: rtl/stack_host_driver.sv
// Initiator for the 8-bit push/pop stack pin protocol: turns single-word push/pop
// commands into the strobe/bus/done sequence and tracks stack occupancy locally.
module stack_host_driver #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [WIDTH-1:0]           cmd_wdata,
  output logic                       rsp_valid,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                 rsp_err,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [WIDTH-1:0]           stk_data_out,
  output logic [WIDTH-1:0]           stk_data_oe,
  input  logic [WIDTH-1:0]           stk_data_in,
  input  logic                       stk_done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_TMOUT = 2'b11;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic             op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] rdata_reg, rdata_next;
  logic [1:0]       err_reg, err_next;
  logic             drive;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= 1'b0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= ERR_OK;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op;
          data_next = cmd_wdata;
          // Full/empty is known locally, so bad commands never touch the pins
          if (!cmd_op && level_reg == LW'(DEPTH)) begin
            state_next = RESP;
            err_next   = ERR_OVF;
            rdata_next = '0;
          end else if (cmd_op && level_reg == '0) begin
            state_next = RESP;
            err_next   = ERR_UNF;
            rdata_next = '0;
          end else begin
            state_next = SETUP;
          end
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        // stk_done may still show the previous idle level right after the strobe
        if (cnt_reg >= CW'(SETTLE) && stk_done) begin
          state_next = RESP;
          err_next   = ERR_OK;
          rdata_next = op_reg ? stk_data_in : '0;
          level_next = op_reg ? level_reg - LW'(1) : level_reg + LW'(1);
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next = RESP;
          err_next   = ERR_TMOUT;
          rdata_next = '0;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign drive = !op_reg && (state_reg == SETUP || state_reg == STROBE || state_reg == WAIT);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bus
      assign stk_data_oe[gi]  = drive;
      assign stk_data_out[gi] = drive & data_reg[gi];
    end
  endgenerate

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign stk_push  = (state_reg == STROBE) && !op_reg;
  assign stk_pop   = (state_reg == STROBE) && op_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_stack_host_driver.sv
// Directed bench for stack_host_driver with a small external-stack model on the pins.
module tb_stack_host_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_out;
  logic [7:0] stk_data_oe;
  logic [7:0] stk_data_in;
  logic       stk_done;
  logic [4:0] level;

  int tests_run    = 0;
  int tests_failed = 0;

  // Observations from the last run_cmd call
  int         lat;
  int         npush;
  int         npop;
  int         strobe_at;
  int         bad;
  logic [7:0] rd;
  logic [1:0] er;

  stack_host_driver dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_data_out (stk_data_out),
    .stk_data_oe  (stk_data_oe),
    .stk_data_in  (stk_data_in),
    .stk_done     (stk_done),
    .level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack model: captures the bus on push, presents top of stack on pop
  logic [7:0] mem [0:31];
  int         sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp          <= 0;
      stk_data_in <= 8'h00;
    end else if (stk_push && sp < 32) begin
      mem[sp] <= stk_data_out;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data_in <= mem[sp-1];
      sp          <= sp - 1;
    end
  end

  task automatic run_cmd(input logic op, input logic [7:0] wd, input int max_cyc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = -1; npush = 0; npop = 0; strobe_at = -1; bad = 0; rd = 8'h00; er = 2'b00;
    for (int i = 0; i <= max_cyc; i++) begin
      if (stk_push && stk_pop) bad++;
      if (stk_push) begin npush++; strobe_at = i; end
      if (stk_pop)  begin npop++;  strobe_at = i; end
      if (rsp_valid) begin
        lat = i;
        rd  = rsp_rdata;
        er  = rsp_err;
        if (stk_data_oe !== 8'h00 || stk_data_out !== 8'h00 || cmd_ready !== 1'b0) bad++;
        break;
      end
      if (!op && (stk_data_oe !== 8'hFF || stk_data_out !== wd)) bad++;
      if (op && stk_data_oe !== 8'h00) bad++;
      @(posedge clk);
      #1;
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    $display("[TB] %s wd=%02h lat=%0d rd=%02h err=%02b strobes=%0d/%0d@%0d bad=%0d level=%0d",
             op ? "pop " : "push", wd, lat, rd, er, npush, npop, strobe_at, bad, level);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_hs: ready=%b valid=%b, want 1/0", cmd_ready, rsp_valid);
    end
    tests_run++;
    if (rsp_rdata !== 8'h00 || rsp_err !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_rsp: rdata=%02h err=%02b, want 00/00", rsp_rdata, rsp_err);
    end
    tests_run++;
    if (stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_data_oe !== 8'h00 || stk_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_pins: push=%b pop=%b oe=%02h out=%02h, want all 0",
               stk_push, stk_pop, stk_data_oe, stk_data_out);
    end
    tests_run++;
    if (level !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_level: got %0d want 0", level);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_push_pop();
    stk_done = 1'b1;
    run_cmd(1'b0, 8'hA5, 100);
    tests_run++;
    if (lat !== 5 || npush !== 1 || npop !== 0 || strobe_at !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL push_timing: lat=%0d push=%0d pop=%0d at=%0d bad=%0d, want 5/1/0/1/0",
               lat, npush, npop, strobe_at, bad);
    end
    tests_run++;
    if (er !== 2'b00 || rd !== 8'h00 || level !== 5'd1) begin
      tests_failed++;
      $display("FAIL push_rsp: err=%02b rd=%02h level=%0d, want 00/00/1", er, rd, level);
    end
    run_cmd(1'b1, 8'h00, 100);
    tests_run++;
    if (lat !== 5 || npush !== 0 || npop !== 1 || strobe_at !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL pop_timing: lat=%0d push=%0d pop=%0d at=%0d bad=%0d, want 5/0/1/1/0",
               lat, npush, npop, strobe_at, bad);
    end
    tests_run++;
    if (er !== 2'b00 || rd !== 8'hA5 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL pop_rsp: err=%02b rd=%02h level=%0d, want 00/A5/0", er, rd, level);
    end
  endtask

  task automatic test_underflow();
    run_cmd(1'b1, 8'h00, 100);
    tests_run++;
    if (lat !== 0 || er !== 2'b10 || rd !== 8'h00 || npop !== 0 || npush !== 0 || bad !== 0 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL underflow: lat=%0d err=%02b rd=%02h strobes=%0d/%0d bad=%0d level=%0d, want 0/10/00/0/0/0/0",
               lat, er, rd, npush, npop, bad, level);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 16; k++) begin
      run_cmd(1'b0, 8'(k), 100);
      tests_run++;
      if (lat !== 5 || er !== 2'b00 || npush !== 1 || bad !== 0 || level !== 5'(k + 1)) begin
        tests_failed++;
        $display("FAIL fill_%0d: lat=%0d err=%02b push=%0d bad=%0d level=%0d, want 5/00/1/0/%0d",
                 k, lat, er, npush, bad, level, k + 1);
      end
    end
    run_cmd(1'b0, 8'hEE, 100);
    tests_run++;
    if (lat !== 0 || er !== 2'b01 || rd !== 8'h00 || npush !== 0 || bad !== 0 || level !== 5'd16) begin
      tests_failed++;
      $display("FAIL overflow: lat=%0d err=%02b rd=%02h push=%0d bad=%0d level=%0d, want 0/01/00/0/0/16",
               lat, er, rd, npush, bad, level);
    end
  endtask

  task automatic test_lifo();
    for (int k = 0; k < 16; k++) begin
      run_cmd(1'b1, 8'h00, 100);
      tests_run++;
      if (lat !== 5 || er !== 2'b00 || rd !== 8'(15 - k) || npop !== 1 || bad !== 0 || level !== 5'(15 - k)) begin
        tests_failed++;
        $display("FAIL lifo_%0d: lat=%0d err=%02b rd=%02h pop=%0d bad=%0d level=%0d, want 5/00/%02h/1/0/%0d",
                 k, lat, er, rd, npop, bad, level, 15 - k, 15 - k);
      end
    end
  endtask

  task automatic test_timeout();
    stk_done = 1'b0;
    run_cmd(1'b0, 8'h3C, 100);
    tests_run++;
    if (lat !== 66 || npush !== 1 || bad !== 0) begin
      tests_failed++;
      $display("FAIL timeout_timing: lat=%0d push=%0d bad=%0d, want 66/1/0", lat, npush, bad);
    end
    tests_run++;
    if (er !== 2'b11 || rd !== 8'h00 || level !== 5'd0) begin
      tests_failed++;
      $display("FAIL timeout_rsp: err=%02b rd=%02h level=%0d, want 11/00/0", er, rd, level);
    end
    stk_done = 1'b1;
  endtask

  task automatic test_reset_midwait();
    int seen;
    stk_done = 1'b1;
    run_cmd(1'b0, 8'h11, 100);
    tests_run++;
    if (level !== 5'd1 || er !== 2'b00) begin
      tests_failed++;
      $display("FAIL prewait_push: level=%0d err=%02b, want 1/00", level, er);
    end
    stk_done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_wdata = 8'h22;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (stk_data_oe !== 8'h00 || stk_data_out !== 8'h00 || stk_push !== 1'b0 || stk_pop !== 1'b0) begin
      tests_failed++;
      $display("FAIL midwait_pins: oe=%02h out=%02h push=%b pop=%b, want 00/00/0/0",
               stk_data_oe, stk_data_out, stk_push, stk_pop);
    end
    tests_run++;
    if (level !== 5'd0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midwait_state: level=%0d ready=%b valid=%b, want 0/1/0", level, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    stk_done = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midwait_no_rsp: rsp_valid pulses=%0d, want 0", seen);
    end
    run_cmd(1'b0, 8'h77, 100);
    tests_run++;
    if (lat !== 5 || er !== 2'b00 || npush !== 1 || bad !== 0 || level !== 5'd1) begin
      tests_failed++;
      $display("FAIL post_reset_push: lat=%0d err=%02b push=%0d bad=%0d level=%0d, want 5/00/1/0/1",
               lat, er, npush, bad, level);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_wdata = 8'h00;
    stk_done  = 1'b1;
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_lifo();
    test_timeout();
    test_reset_midwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
